lut_table_loader: RTL

- Runtime-programmable LUT neuron layer: the writer side of the LogicNets truth-table neuron.
- Receives truth tables over a valid/ready config stream and stores them per neuron (shadow buffer, then atomic commit).
- Serves registered lookups with the same addressing as the fixed ROM neurons: input code selects a table entry.
- Sits beside the generated layers so a layer's weights can be reloaded without resynthesis.

---
 rtl/lut_cfg_pkg.sv | 27 ++
 rtl/lut_neuron_ram.sv | 38 +++
 rtl/lut_table_loader.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lut_cfg_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT neuron layer.
// Stream layout: header carries the neuron index, data beats fill the table LSB-first.
package lut_cfg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_DRAIN,
    S_COMMIT
  } cfg_state_e;

  localparam int CFG_HDR_IDX_LSB    = 0;
  localparam bit CFG_BEAT_LSB_FIRST = 1'b1;

  function automatic int table_bits(input int in_bits, input int out_bits);
    return (2 ** in_bits) * out_bits;
  endfunction

  function automatic int beats(input int in_bits, input int out_bits, input int cfg_w);
    return table_bits(in_bits, out_bits) / cfg_w;
  endfunction

  function automatic int idx_w(input int num_neurons);
    return (num_neurons > 1) ? $clog2(num_neurons) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron's truth table: whole-table commit port plus a registered lookup port.
// Reads sampled on the commit edge see the previous contents.
module lut_neuron_ram
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     we_i,
  input  logic [table_bits(IN_BITS, OUT_BITS)-1:0] wdata_i,
  input  logic                                     rd_en_i,
  input  logic                                     valid_i,
  input  logic [IN_BITS-1:0]                       raddr_i,
  output logic [OUT_BITS-1:0]                      rdata_o
);

  localparam int DEPTH = 2 ** IN_BITS;

  logic [OUT_BITS-1:0] mem [DEPTH];
  logic [OUT_BITS-1:0] rdata_q;

  // Table contents are deliberately left unreset; the loaded bit gates them instead.
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (we_i) mem[e] <= wdata_i[e*OUT_BITS +: OUT_BITS];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else if (rd_en_i) rdata_q <= valid_i ? mem[raddr_i] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_table_loader.sv
// Runtime-programmable LUT neuron layer: config stream into a shadow buffer,
// atomic per-neuron commit, and one-cycle registered lookups.
module lut_table_loader
  import lut_cfg_pkg::*;
#(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 16,
  parameter int CFG_W       = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [CFG_W-1:0]                cfg_data,
  input  logic                            cfg_last,
  input  logic                            cfg_err_clr,
  output logic                            cfg_err,
  output logic                            busy,
  output logic [NUM_NEURONS-1:0]          loaded,
  input  logic                            in_valid,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data
);

  localparam int TABLE_BITS = table_bits(IN_BITS, OUT_BITS);
  localparam int BEATS      = beats(IN_BITS, OUT_BITS, CFG_W);
  localparam int IDX_W      = idx_w(NUM_NEURONS);
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W      = (TABLE_BITS > 1) ? $clog2(TABLE_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BEATS - 1);
  localparam logic [CFG_W:0]   NUM_LIMIT = (CFG_W + 1)'(NUM_NEURONS);

  cfg_state_e             state_q;
  logic                   cfgReady_q;
  logic                   busy_q;
  logic                   cfgErr_q;
  logic [NUM_NEURONS-1:0] loaded_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [TABLE_BITS-1:0]  shadow_q;
  logic                   outValid_q;

  logic             cfgAccept;
  logic             hdrOutOfRange;
  logic             commitEn;
  logic [OFF_W-1:0] beatOff;

  assign cfgAccept = cfg_valid && cfgReady_q;
  assign commitEn  = (state_q == S_COMMIT);

  // The range check looks at the whole header beat, so an index that would
  // alias into range after truncation to IDX_W bits is still rejected.
  always_comb begin
    hdrOutOfRange = ({1'b0, cfg_data} >= NUM_LIMIT);
    beatOff = CFG_BEAT_LSB_FIRST ? OFF_W'(cnt_q) * OFF_W'(CFG_W)
                                 : (OFF_W'(LAST_CNT) - OFF_W'(cnt_q)) * OFF_W'(CFG_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cfgReady_q <= 1'b0;
      busy_q     <= 1'b0;
      cfgErr_q   <= 1'b0;
      loaded_q   <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
    end else begin
      cfgReady_q <= 1'b1;
      // Clear is issued first so any error raised this cycle overrides it.
      if (cfg_err_clr) cfgErr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfgAccept) begin
            if (hdrOutOfRange) begin
              cfgErr_q <= 1'b1;
              if (!cfg_last) begin
                state_q <= S_DRAIN;
                busy_q  <= 1'b1;
              end
            end else if (cfg_last) begin
              cfgErr_q <= 1'b1;
            end else begin
              state_q <= S_DATA;
              busy_q  <= 1'b1;
              idx_q   <= cfg_data[CFG_HDR_IDX_LSB +: IDX_W];
              cnt_q   <= '0;
            end
          end
        end
        S_DATA: begin
          if (cfgAccept) begin
            shadow_q[beatOff +: CFG_W] <= cfg_data;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              if (cfg_last) begin
                state_q    <= S_COMMIT;
                cfgReady_q <= 1'b0;
              end else begin
                cfgErr_q <= 1'b1;
                state_q  <= S_DRAIN;
              end
            end else if (cfg_last) begin
              cfgErr_q <= 1'b1;
              shadow_q <= '0;
              state_q  <= S_IDLE;
              busy_q   <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (cfgAccept && cfg_last) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_COMMIT: begin
          loaded_q[idx_q] <= 1'b1;
          state_q         <= S_IDLE;
          busy_q          <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) outValid_q <= 1'b0;
    else outValid_q <= in_valid;
  end

  for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
    lut_neuron_ram #(
      .IN_BITS (IN_BITS),
      .OUT_BITS(OUT_BITS)
    ) u_ram (
      .clk_i  (clk),
      .rst_i  (rst),
      .we_i   (commitEn && (idx_q == IDX_W'(n))),
      .wdata_i(shadow_q),
      .rd_en_i(in_valid),
      .valid_i(loaded_q[n]),
      .raddr_i(in_data[n*IN_BITS +: IN_BITS]),
      .rdata_o(out_data[n*OUT_BITS +: OUT_BITS])
    );
  end

  assign cfg_ready = cfgReady_q;
  assign cfg_err   = cfgErr_q;
  assign busy      = busy_q;
  assign loaded    = loaded_q;
  assign out_valid = outValid_q;

endmodule
